// File: rtl/detector_link_filter_pkg.sv
// Shared types and constants for the detector link filter.
package detector_pkg;

  typedef enum logic [1:0] {
    LINK_DOWN = 2'd0,
    SYNCING   = 2'd1,
    LINK_UP   = 2'd2
  } link_state_t;

  localparam logic [3:0] DET_SAFE = 4'b1111;

  localparam int unsigned DET_FRONT = 0;
  localparam int unsigned DET_LEFT  = 1;
  localparam int unsigned DET_RIGHT = 2;
  localparam int unsigned DET_BACK  = 3;

  localparam int unsigned MATCH_W = 4;
  localparam int unsigned BAD_W   = 8;

  // Received byte layout: header in the upper nibble, detector bits below.
  typedef struct packed {
    logic [3:0] hdr;
    logic [3:0] det;
  } rx_frame_t;

endpackage

// File: rtl/detector_link_filter_if.sv
// Byte stream from the UART receiver into the detector link filter.
interface detector_link_filter_if;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/detector_link_filter_watchdog.sv
// Link watchdog: counts cycles since the last valid frame and flags expiry.
module link_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  output logic timeout
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // timeout is high while the count sits at its last value; a kick on that
  // edge takes priority in the consumer, so the link survives.
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (kick || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      timeout <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      timeout <= (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/detector_link_filter.sv
// Header check, frame debounce and link supervision for the detector byte.
// Optional DETECTOR_EDGE_EN adds det_rise, a per-bit 0->1 pulse output.
module detector_link_filter
  import detector_pkg::*;
#(
  parameter logic [3:0]  HDR            = 4'b0000,
  parameter int unsigned STABLE_FRAMES  = 3,
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  detector_link_filter_if.slave  rx,
  output logic                   front_detector,
  output logic                   left_detector,
  output logic                   right_detector,
  output logic                   back_detector,
  output logic                   link_up,
  output logic [BAD_W-1:0]       bad_frame_cnt
`ifdef DETECTOR_EDGE_EN
  ,
  output logic [3:0]             det_rise
`endif
);

  localparam logic [MATCH_W-1:0] STABLE_N = MATCH_W'(STABLE_FRAMES);

  link_state_t        state_q, state_d;
  logic [3:0]         det_q, det_d;
  logic [3:0]         cand_q, cand_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [BAD_W-1:0]   bad_q, bad_d;
  logic               up_q, up_d;
  rx_frame_t          frame;
  logic               valid_frame, bad_frame, timeout;

  assign frame       = rx_frame_t'(rx.rx_data);
  assign valid_frame = rx.rx_valid && (frame.hdr == HDR);
  assign bad_frame   = rx.rx_valid && (frame.hdr != HDR);

  link_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .kick    (valid_frame),
    .timeout (timeout)
  );

  always_comb begin
    state_d = state_q;
    det_d   = det_q;
    cand_d  = cand_q;
    match_d = match_q;
    bad_d   = bad_q;

    if (bad_frame && bad_q != '1) bad_d = bad_q + BAD_W'(1);

    if (valid_frame) begin
      if (frame.det == cand_q && match_q != '0) begin
        match_d = (match_q == STABLE_N) ? STABLE_N : match_q + MATCH_W'(1);
      end else begin
        cand_d  = frame.det;
        match_d = MATCH_W'(1);
      end
      // A qualifying frame loads the outputs from any state.
      if (match_d == STABLE_N) begin
        state_d = LINK_UP;
        det_d   = cand_d;
      end else if (state_q == LINK_DOWN) begin
        state_d = SYNCING;
      end
    end else if (timeout && state_q != LINK_DOWN) begin
      state_d = LINK_DOWN;
      det_d   = DET_SAFE;
      cand_d  = '0;
      match_d = '0;
    end

    up_d = (state_d == LINK_UP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LINK_DOWN;
      det_q   <= DET_SAFE;
      cand_q  <= '0;
      match_q <= '0;
      bad_q   <= '0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      det_q   <= det_d;
      cand_q  <= cand_d;
      match_q <= match_d;
      bad_q   <= bad_d;
      up_q    <= up_d;
    end
  end

`ifdef DETECTOR_EDGE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) det_rise <= '0;
    else      det_rise <= det_d & ~det_q;
  end
`endif

  assign front_detector = det_q[DET_FRONT];
  assign left_detector  = det_q[DET_LEFT];
  assign right_detector = det_q[DET_RIGHT];
  assign back_detector  = det_q[DET_BACK];
  assign link_up        = up_q;
  assign bad_frame_cnt  = bad_q;

endmodule

// File: tb/tb_detector_link_filter.sv
// Self-checking bench for detector_link_filter with a frame-history reference model.
module tb_detector_link_filter;

  localparam logic [3:0] HDR = 4'b0000;
  localparam int S = 3;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic front_detector, left_detector, right_detector, back_detector, link_up;
  logic [7:0] bad_frame_cnt;
`ifdef DETECTOR_EDGE_EN
  logic [3:0] det_rise;
`endif

  detector_link_filter_if rxi ();

  detector_link_filter #(.HDR(HDR), .STABLE_FRAMES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx             (rxi.slave),
    .front_detector (front_detector),
    .left_detector  (left_detector),
    .right_detector (right_detector),
    .back_detector  (back_detector),
    .link_up        (link_up),
    .bad_frame_cnt  (bad_frame_cnt)
`ifdef DETECTOR_EDGE_EN
    ,
    .det_rise       (det_rise)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the valid nibbles seen since the link last went down,
  // plus a count of frame-less edges.
  logic [3:0] m_det, m_rise;
  logic       m_up, m_active;
  int         m_bad, m_gap;
  logic [3:0] hist[$];

  function automatic logic [3:0] dut_det();
    return {back_detector, right_detector, left_detector, front_detector};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_det = 4'hF; m_rise = 4'h0; m_up = 1'b0; m_active = 1'b0;
    m_bad = 0; m_gap = 0; hist.delete();
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    logic [3:0] old_det;
    logic       qual;
    old_det = m_det;
    if (v && d[7:4] != HDR && m_bad < 255) m_bad++;
    if (v && d[7:4] == HDR) begin
      m_gap = 0;
      m_active = 1'b1;
      hist.push_back(d[3:0]);
      if (hist.size() > S) void'(hist.pop_front());
      qual = (hist.size() == S);
      foreach (hist[k]) if (hist[k] != d[3:0]) qual = 1'b0;
      if (qual) begin
        m_det = d[3:0];
        m_up  = 1'b1;
      end
    end else begin
      m_gap++;
      if (m_gap == T) begin
        m_gap = 0;
        if (m_active) begin
          m_active = 1'b0;
          m_up = 1'b0;
          m_det = 4'hF;
          hist.delete();
        end
      end
    end
    m_rise = m_det & ~old_det;
  endtask

  task automatic compare_model();
    chk("det", 32'(dut_det()), 32'(m_det));
    chk("link_up", 32'(link_up), 32'(m_up));
    chk("bad_frame_cnt", 32'(bad_frame_cnt), 32'(m_bad));
`ifdef DETECTOR_EDGE_EN
    chk("det_rise", 32'(det_rise), 32'(m_rise));
`endif
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    rxi.rx_valid = v;
    rxi.rx_data  = d;
    @(posedge clk);
    model_step(v, d);
    #1;
    compare_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [3:0] det;
    logic       up;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 8'h05, 4'hF, 1'b0};
    tbl[1] = '{1'b1, 8'h05, 4'hF, 1'b0};
    tbl[2] = '{1'b1, 8'h05, 4'h5, 1'b1};
    tbl[3] = '{1'b1, 8'h06, 4'h5, 1'b1};
    tbl[4] = '{1'b1, 8'h06, 4'h5, 1'b1};
    tbl[5] = '{1'b1, 8'h05, 4'h5, 1'b1};
    tbl[6] = '{1'b1, 8'h03, 4'h5, 1'b1};
    tbl[7] = '{1'b1, 8'h03, 4'h5, 1'b1};
    tbl[8] = '{1'b1, 8'h03, 4'h3, 1'b1};

    rxi.rx_valid = 1'b0;
    rxi.rx_data  = 8'h00;
    model_reset();
    #12;
    chk("reset_det", 32'(dut_det()), 32'hF);
    chk("reset_link_up", 32'(link_up), 32'h0);
    chk("reset_bad", 32'(bad_frame_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // No frames for longer than the timeout: link stays down.
    idle(T + 4);
    chk("idle_link_down", 32'(link_up), 32'h0);
    chk("idle_det_safe", 32'(dut_det()), 32'hF);

    // Sync, hold against a broken run, then switch to 0x3.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_det", i), 32'(dut_det()), 32'(tbl[i].det));
      chk($sformatf("tbl%0d_up", i), 32'(link_up), 32'(tbl[i].up));
    end

    // A valid frame on the T-th idle edge keeps the link.
    idle(T - 1);
    chk("pre_timeout_up", 32'(link_up), 32'h1);
    step(1'b1, 8'h03);
    chk("kick_on_timeout_edge", 32'(link_up), 32'h1);
    idle(T - 1);
    chk("edge_before_timeout", 32'(link_up), 32'h1);
    idle(1);
    chk("timeout_link_down", 32'(link_up), 32'h0);
    chk("timeout_det_safe", 32'(dut_det()), 32'hF);

    // Bad headers saturate the counter and do not refresh the watchdog.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h05);
    chk("resync_up", 32'(link_up), 32'h1);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 8'hA5);
      if (i == 14) chk("bad15_still_up", 32'(link_up), 32'h1);
      if (i == 15) chk("bad16_timeout", 32'(link_up), 32'h0);
      if (i == 253) chk("bad_cnt_254", 32'(bad_frame_cnt), 32'd254);
    end
    chk("bad_cnt_sat", 32'(bad_frame_cnt), 32'd255);
    chk("bad_det_safe", 32'(dut_det()), 32'hF);

`ifdef DETECTOR_EDGE_EN
    // 0x0 -> 0x5 -> forced 0xF, checking the rise pulses.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h00);
    chk("edge_det0", 32'(dut_det()), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h05);
    chk("rise_0101", 32'(det_rise), 32'h5);
    idle(1);
    chk("rise_0101_once", 32'(det_rise), 32'h0);
    idle(T - 1);
    chk("rise_1010", 32'(det_rise), 32'hA);
    idle(1);
    chk("rise_1010_once", 32'(det_rise), 32'h0);
`endif

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h09);
    chk("pre_reset_up", 32'(link_up), 32'h1);
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_det", 32'(dut_det()), 32'hF);
    chk("async_rst_up", 32'(link_up), 32'h0);
    chk("async_rst_bad", 32'(bad_frame_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the model.
    begin
      logic [3:0] nib;
      int r;
      nib = 4'h0;
      for (int i = 0; i < 2000; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 2) begin
          idle(int'($urandom_range(8, 24)));
        end else if (r < 40) begin
          step(1'b0, 8'($urandom));
        end else if (r < 85) begin
          if ($urandom_range(0, 9) < 4) nib = 4'($urandom);
          step(1'b1, {HDR, nib});
        end else begin
          step(1'b1, {4'($urandom_range(1, 15)), 4'($urandom)});
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/detector_link_filter.md
Name: detector_link_filter

Overview:
- Consumes bytes from the UART receiver that carry the simulated device's detector status, and drives the four detector outputs.
- Validates each frame header and debounces the detector nibble across consecutive frames.
- Runs a link watchdog. On loss of link it forces a safe "obstacle everywhere" value.
- Sits directly downstream of the UART receive path in the device top, replacing the raw bit-slicing of the received byte.

Parameters:
- HDR, 4'b0000, required value of rx_data[7:4] for a frame to be valid.
- STABLE_FRAMES, 3, number of consecutive identical valid nibbles needed before outputs update (range 1..15; 1 = pass-through).
- TIMEOUT_CYCLES, 10_000_000, clk cycles without a valid frame before the link is declared down (100 ms at 100 MHz; minimum 2).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous reset, active-low.
- rx_data  in  8  received byte; bit 0 front, 1 left, 2 right, 3 back, [7:4] header.
- rx_valid  in  1  one-cycle strobe; rx_data is valid while high.
- front_detector  out  1  debounced front detector.
- left_detector  out  1  debounced left detector.
- right_detector  out  1  debounced right detector.
- back_detector  out  1  debounced back detector.
- link_up  out  1  high while the link is in LINK_UP.
- bad_frame_cnt  out  8  count of header-mismatched frames, saturating.

Behaviour:
- rst low, asynchronous: all four detectors = 1, link_up = 0, bad_frame_cnt = 0, state = LINK_DOWN, candidate = 0, match_cnt = 0, watchdog = 0. All outputs are registered.
- Frame accept: rx_valid high at a rising edge.
  - Valid frame: rx_data[7:4] == HDR.
  - Invalid frame: bad_frame_cnt += 1, saturating at 255. Nothing else changes and the watchdog is not refreshed.
- Debounce, on each valid frame with nibble n:
  - If n == candidate and match_cnt != 0: match_cnt = min(match_cnt + 1, STABLE_FRAMES).
  - Otherwise: candidate = n, match_cnt = 1.
- Qualifying frame: a valid frame after which match_cnt == STABLE_FRAMES.
  - On that same edge, detectors <= candidate. Outputs are visible the cycle after the accepting edge.
- Watchdog:
  - Cleared to 0 on each valid frame; otherwise increments.
  - Timeout fires when it reaches TIMEOUT_CYCLES-1 with no valid frame on that edge.
  - A valid frame on the timeout edge wins: no timeout.
- States:
  - LINK_DOWN: detectors held at 4'b1111. The first valid frame moves to SYNCING, or directly to LINK_UP if STABLE_FRAMES = 1.
  - SYNCING: detectors still held at 4'b1111. A qualifying frame moves to LINK_UP, with link_up = 1 and detectors loaded on the same edge. Timeout moves to LINK_DOWN.
  - LINK_UP: detectors follow qualifying frames. Non-qualifying frames leave the outputs unchanged. Timeout moves to LINK_DOWN: detectors = 4'b1111, link_up = 0, candidate = 0, match_cnt = 0. bad_frame_cnt is preserved.
- Reset asserted mid-operation returns all state to the reset values immediately, regardless of the current state.
- rx_valid held high for multiple cycles: each cycle counts as a separate frame.

Optional Feature:
- Macro DETECTOR_EDGE_EN.
- When defined:
  - Adds output det_rise [3:0], a registered one-cycle pulse per detector bit on each 0->1 transition.
  - Pulses fire on both qualifying updates and the forced-safe value applied at timeout.
  - det_rise resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package detector_pkg:
  - link state encoding LINK_DOWN = 2'd0, SYNCING = 2'd1, LINK_UP = 2'd2;
  - DET_SAFE = 4'b1111;
  - bit indices DET_FRONT = 0, DET_LEFT = 1, DET_RIGHT = 2, DET_BACK = 3.
- One sub-module, link_watchdog:
  - counter of width $clog2(TIMEOUT_CYCLES);
  - inputs kick (valid frame) and clk/rst;
  - output timeout (one-cycle pulse).

Test Plan:
- Reset, then no frames → detectors = 1111, link_up = 0, bad_frame_cnt = 0; after TIMEOUT_CYCLES still LINK_DOWN.
- Three valid frames 8'h05 → link_up = 1 and detectors front = 1, left = 0, right = 1, back = 0, one cycle after the third strobe; after only two frames, still 1111.
- In LINK_UP with 0x05, send 0x06, 0x06, 0x05 → outputs stay 0x5. Then 0x03 ×3 → outputs change to 0x3 after the third frame.
- Send 8'hA5 ×300 → bad_frame_cnt saturates at 255; detectors and state unchanged. From LINK_UP, timeout still fires since bad frames do not refresh the watchdog.
- Run TIMEOUT_CYCLES = 16, link up, then stop frames → link_up drops and detectors = 1111 after 16 cycles. A valid frame exactly on the 16th edge prevents the timeout.
- With DETECTOR_EDGE_EN, outputs go 0x0 → 0x5 → forced 0xF → det_rise pulses 0101, then 1010, each for one cycle.
